// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter sharing one DRAM port among NUM_CORES cores, with broadcast reads.
// Define ARB_FIXED_PRIO_EN to make the lowest eligible index win instead of round-robin.
module mem_arbiter_rr #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES-1:0]        bcast,
  input  logic [NUM_CORES*ADDR_W-1:0] ar_in,
  input  logic [NUM_CORES*DATA_W-1:0] bus_in,
  input  logic [NUM_CORES-1:0]        end_process,
  output logic [NUM_CORES-1:0]        grant,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_CORES*DATA_W-1:0] rdata,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic                        busy
);
  localparam int IW = $clog2(NUM_CORES);
  localparam int CW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, win_idx, sel;
  logic [CW-1:0] cnt;
  logic bc, is_wr;
  logic [NUM_CORES-1:0] elig;
  assign elig = req & ~end_process;
  // Scanning a doubled index range from rr_ptr handles the wrap without modular arithmetic on rr_ptr.
  always_comb begin
    sel = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = NUM_CORES-1; k >= 0; k--)
      if (elig[k]) sel = IW'(k);
`else
    for (int k = 2*NUM_CORES-1; k >= 0; k--)
      if (elig[k % NUM_CORES] && k >= int'(rr_ptr)) sel = IW'(k % NUM_CORES);
`endif
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_idx   <= '0;
      cnt       <= '0;
      bc        <= 1'b0;
      is_wr     <= 1'b0;
      grant     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      rvalid    <= '0;
      busy      <= 1'b0;
    end else begin
      grant  <= '0;
      mem_en <= 1'b0;
      rvalid <= '0;
      case (state)
        IDLE: if (|elig) begin
          grant     <= NUM_CORES'(1) << sel;
          mem_en    <= 1'b1;
          mem_we    <= we[sel];
          mem_addr  <= ar_in[sel*ADDR_W +: ADDR_W];
          mem_wdata <= bus_in[sel*DATA_W +: DATA_W];
          win_idx   <= sel;
          bc        <= bcast[sel] & ~we[sel];
          is_wr     <= we[sel];
          rr_ptr    <= (sel == IW'(NUM_CORES-1)) ? '0 : sel + 1'b1;
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          cnt   <= CW'(RD_LAT - 1);
          busy  <= ~is_wr;
          state <= is_wr ? IDLE : (RD_LAT > 1 ? WAIT : RESP);
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= RESP;
        end
        RESP: begin
          for (int i = 0; i < NUM_CORES; i++)
            if (bc || win_idx == IW'(i)) rdata[i*DATA_W +: DATA_W] <= mem_rdata;
          rvalid <= bc ? '1 : NUM_CORES'(1) << win_idx;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: scoreboard bench for mem_arbiter_rr with a RD_LAT=3 DRAM model.
module tb_mem_arbiter_rr;
  localparam int N = 4;
  localparam int RD_LAT = 3;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0, we = '0, bcast = '0, end_process = '0;
  logic [N*16-1:0] ar_in = '0, bus_in = '0;
  logic [N-1:0] grant, rvalid;
  logic mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [N*16-1:0] rdata;
  int vecs = 0, errs = 0, cyc = 0, c;
  logic [N*16-1:0] exp_rd = '0;
  logic [15:0] pipe [RD_LAT];
  typedef struct {logic [N-1:0] g; logic w; logic [15:0] a; logic [15:0] d; int c;} gexp_t;
  typedef struct {logic [N-1:0] v; logic [N*16-1:0] rd; int c;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  mem_arbiter_rr #(.NUM_CORES(N), .ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .bcast(bcast), .ar_in(ar_in),
    .bus_in(bus_in), .end_process(end_process), .grant(grant), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rdata(rdata),
    .rvalid(rvalid), .busy(busy));

  always #5 clock = ~clock;
  always @(posedge clock or negedge reset_n) cyc <= !reset_n ? 0 : cyc + 1;

  function automatic logic [15:0] dram_data(input logic [15:0] a);
    return a == 16'h0040 ? 16'hBEEF : a == 16'h0000 ? 16'h1234 : a ^ 16'h5A5A;
  endfunction

  always @(posedge clock) begin
    pipe[0] <= (mem_en && !mem_we) ? dram_data(mem_addr) : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h (edge %0d)", n, a, e, cyc);
    end
  endtask

  task automatic check_reset();
    chk("rst_grant", 64'(grant), 0);
    chk("rst_mem_en", 64'(mem_en), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_busy", 64'(busy), 0);
  endtask

  task automatic init_data();
    for (int i = 0; i < N; i++) begin
      ar_in[i*16 +: 16] = 16'h0100 + 16'(i);
      bus_in[i*16 +: 16] = 16'hD000 + 16'(i * 16'h0111);
    end
    req = '0; we = '0; bcast = '0; end_process = '0;
  endtask

  task automatic exp_grant(input int core, input logic w, input int e);
    gq.push_back('{g: N'(1) << core, w: w, a: ar_in[core*16 +: 16], d: bus_in[core*16 +: 16], c: e});
  endtask

  task automatic exp_read(input int core, input logic b, input logic [15:0] a, input int e);
    for (int i = 0; i < N; i++) if (b || i == core) exp_rd[i*16 +: 16] = dram_data(a);
    rq.push_back('{v: b ? {N{1'b1}} : N'(1) << core, rd: exp_rd, c: e});
  endtask

  task automatic set_read(input int core, input logic b, input logic [15:0] a);
    req[core] = 1'b1; we[core] = 1'b0; bcast[core] = b; ar_in[core*16 +: 16] = a;
  endtask

  always @(negedge clock) if (reset_n) begin
    if (grant != 0 || mem_en) begin
      if (gq.size() == 0) chk("unexpected_grant", 64'({mem_en, grant}), 0);
      else begin
        automatic gexp_t e = gq.pop_front();
        chk("grant", 64'(grant), 64'(e.g));
        chk("grant_edge", 64'(cyc), 64'(e.c));
        chk("mem_en", 64'(mem_en), 1);
        chk("mem_we", 64'(mem_we), 64'(e.w));
        chk("mem_addr", 64'(mem_addr), 64'(e.a));
        if (e.w) chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
      end
    end
    if (rvalid != 0) begin
      if (rq.size() == 0) chk("unexpected_rvalid", 64'(rvalid), 0);
      else begin
        automatic rexp_t e = rq.pop_front();
        chk("rvalid", 64'(rvalid), 64'(e.v));
        chk("rvalid_edge", 64'(cyc), 64'(e.c));
        chk("rdata", rdata, e.rd);
      end
    end
  end

  initial begin
    repeat (4) begin
      @(negedge clock);
      req = 4'($urandom); we = 4'($urandom); bcast = 4'($urandom); end_process = 4'($urandom);
      ar_in = {$urandom, $urandom}; bus_in = {$urandom, $urandom};
      #1 check_reset();
    end
    init_data();
`ifndef ARB_FIXED_PRIO_EN
    req = '1; we = '1;
    for (int k = 0; k < 5; k++) exp_grant(k % N, 1'b1, 2*k + 1);
    @(negedge clock) reset_n = 1'b1;
    repeat (9) @(negedge clock);
    req = '0;
`else
    req = 4'b1010; we = 4'b1010;
    for (int k = 0; k < 4; k++) exp_grant(1, 1'b1, 2*k + 1);
    @(negedge clock) reset_n = 1'b1;
    repeat (7) @(negedge clock);
    req = '0;
`endif
    repeat (3) @(negedge clock);
    c = cyc;
    set_read(2, 1'b0, 16'h0040);
    exp_grant(2, 1'b0, c + 1);
    exp_read(2, 1'b0, 16'h0040, c + 5);
    @(negedge clock) req = '0;
    repeat (6) @(negedge clock);
    c = cyc;
    req = 4'b0011; we = 4'b0011; end_process = 4'b0010;
    for (int k = 0; k < 3; k++) exp_grant(0, 1'b1, c + 2*k + 1);
    repeat (5) @(negedge clock);
    req = 4'b0010;
    repeat (4) @(negedge clock);
    c = cyc;
    end_process = '0;
    exp_grant(1, 1'b1, c + 1);
    @(negedge clock) req = '0;
    repeat (3) @(negedge clock);
    c = cyc;
    end_process = 4'b1000;
    set_read(0, 1'b1, 16'h0000);
    exp_grant(0, 1'b0, c + 1);
    exp_read(0, 1'b1, 16'h0000, c + 5);
    @(negedge clock) req = '0;
    repeat (7) @(negedge clock);
    c = cyc;
    end_process = '0; bcast = '0;
    set_read(1, 1'b0, 16'h0050);
    exp_grant(1, 1'b0, c + 1);
    @(negedge clock) req = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    exp_rd = '0;
    #1 check_reset();
    @(negedge clock) reset_n = 1'b1;
    repeat (8) @(negedge clock);
`ifndef ARB_FIXED_PRIO_EN
    c = cyc;
    set_read(1, 1'b0, 16'h0061);
    set_read(3, 1'b0, 16'h0063);
    exp_grant(1, 1'b0, c + 1);
    exp_read(1, 1'b0, 16'h0061, c + 5);
    exp_grant(3, 1'b0, c + 6);
    exp_read(3, 1'b0, 16'h0063, c + 10);
    @(negedge clock) req[1] = 1'b0;
    repeat (5) @(negedge clock);
    req[3] = 1'b0;
    repeat (6) @(negedge clock);
`endif
    chk("grant_queue_drained", 64'(gq.size()), 0);
    chk("rvalid_queue_drained", 64'(rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
